// File: rtl/ddr3_avmm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_avmm_pkg
// Brief    : Shared types and constants for the DDR3 Avalon-MM responder:
//            FSM state encodings, read-command record, stall LFSR constants.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_avmm_pkg;

    // Widest RAM index the 29-bit byte address can carry (bits [28:3]).
    localparam int C_IDX_W_MAX = 26;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback taps
    // sit at bit positions 0, 2, 3 and 5 of the current state.
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] C_LFSR_TAPS = 16'h002D;

    typedef enum logic [0:0] {
        WR_IDLE  = 1'b0,
        WR_BURST = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE  = 1'b0,
        RD_ISSUE = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [C_IDX_W_MAX-1:0] index;
        logic [7:0]             burstcount;
    } rd_cmd_t;

    // One LFSR step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & C_LFSR_TAPS), s[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_rd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : avmm_rd_cmd_fifo
// Brief    : Synchronous FIFO of pending read commands with full/empty flags
//            and an occupancy count. Pushes while full and pops while empty
//            are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_rd_cmd_fifo
    import ddr3_avmm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  rd_cmd_t                 i_push_data,
    input  logic                    i_pop,
    output rd_cmd_t                 o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int C_AW = $clog2(DEPTH);
    localparam logic [C_AW:0] C_PTR_ONE = {{C_AW{1'b0}}, 1'b1};

    rd_cmd_t         r_mem [DEPTH];
    logic [C_AW:0]   r_wptr;
    logic [C_AW:0]   r_rptr;

    // Storage write; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wptr[C_AW-1:0]] <= i_push_data;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) r_wptr <= r_wptr + C_PTR_ONE;
            if (i_pop && !o_empty) r_rptr <= r_rptr + C_PTR_ONE;
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                     (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
    assign o_count = r_wptr - r_rptr;
    assign o_head  = r_mem[r_rptr[C_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ddr3_avmm_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_avmm_responder
// Brief    : Avalon-MM 64-bit RAM-backed responder standing in for the DDR3
//            controller port: burst writes, queued burst reads with a fixed
//            latency pipeline and optional pseudo-random waitrequest stalls.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_avmm_responder
    import ddr3_avmm_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 4,
    parameter int CMD_DEPTH  = 4,
    parameter int STALL_EN   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [28:0] avs_address,
    input  logic [7:0]  avs_burstcount,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [63:0] avs_writedata,
    input  logic [7:0]  avs_byteenable,
    output logic [63:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_waitrequest,
    output logic [15:0] dbg_rd_beats,
    output logic [15:0] dbg_wr_beats,
    output logic [3:0]  dbg_outstanding
);

    localparam int C_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] C_IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [63:0]             r_mem [C_DEPTH];
    logic                    r_ready;
    logic [15:0]             r_lfsr;
    logic                    w_stall;
    logic                    w_rd_busy;
    logic                    w_waitrequest;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [ADDR_W-1:0]       w_addr_idx;
    logic [ADDR_W-1:0]       w_wr_idx;

    wr_state_t               r_wr_state, w_wr_state_nxt;
    logic [ADDR_W-1:0]       r_wr_ptr,   w_wr_ptr_nxt;
    logic [7:0]              r_wr_rem,   w_wr_rem_nxt;

    rd_state_t               r_rd_state, w_rd_state_nxt;
    logic [ADDR_W-1:0]       r_rd_ptr,   w_rd_ptr_nxt;
    logic [7:0]              r_rd_rem,   w_rd_rem_nxt;
    logic                    w_pop;
    logic                    w_issue;
    logic [ADDR_W-1:0]       w_head_ptr;
    logic [7:0]              w_head_len;

    rd_cmd_t                 w_push_cmd;
    rd_cmd_t                 w_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [$clog2(CMD_DEPTH):0] w_fifo_count;

    logic [RD_LATENCY-1:0]   r_vld;
    logic [63:0]             r_dat [RD_LATENCY];
    logic [15:0]             r_rd_beats;
    logic [15:0]             r_wr_beats;
    logic                    w_unused_bits;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_addr_idx = avs_address[ADDR_W+2:3];
    assign w_stall    = (STALL_EN != 0) ? (r_lfsr[0] & r_lfsr[3]) : 1'b0;
    assign w_rd_busy  = !w_fifo_empty || (r_rd_state != RD_IDLE);

    // Writes wait for all reads to leave the FIFO/engine so a read can never
    // observe a write that was presented after it.
    assign w_waitrequest = !r_ready || w_stall ||
                           (avs_read  && (w_fifo_full || (r_wr_state == WR_BURST))) ||
                           (avs_write && w_rd_busy);

    // A simultaneous read+write is treated as a write only.
    assign w_wr_acc = avs_write && !w_waitrequest;
    assign w_rd_acc = avs_read && !avs_write && !w_waitrequest;

    // Ready rises on the first edge after reset release; LFSR free-runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_lfsr  <= C_LFSR_SEED;
        end else begin
            r_ready <= 1'b1;
            r_lfsr  <= lfsr_next(r_lfsr);
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign w_wr_idx = (r_wr_state == WR_BURST) ? r_wr_ptr : w_addr_idx;

    // Burst tracking: next beat index and beats still to come.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_wr_rem_nxt   = r_wr_rem;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_wr_acc && (avs_burstcount > 8'd1)) begin
                    w_wr_state_nxt = WR_BURST;
                    w_wr_ptr_nxt   = w_addr_idx + C_IDX_ONE;
                    w_wr_rem_nxt   = avs_burstcount - 8'd1;
                end
            end
            WR_BURST: begin
                if (w_wr_acc) begin
                    w_wr_ptr_nxt = r_wr_ptr + C_IDX_ONE;
                    w_wr_rem_nxt = r_wr_rem - 8'd1;
                    if (r_wr_rem == 8'd1) w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= WR_IDLE;
            r_wr_ptr   <= '0;
            r_wr_rem   <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_wr_rem   <= w_wr_rem_nxt;
        end
    end

    // RAM write port with per-byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int b = 0; b < 8; b++) begin
                if (avs_byteenable[b]) r_mem[w_wr_idx][8*b +: 8] <= avs_writedata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read command queue and issue engine
    // ------------------------------------------------------------------
    assign w_push_cmd.index      = C_IDX_W_MAX'(w_addr_idx);
    assign w_push_cmd.burstcount = avs_burstcount;

    avmm_rd_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_rd_cmd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_rd_acc),
        .i_push_data (w_push_cmd),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_head_ptr = w_head.index[ADDR_W-1:0];
    assign w_head_len = (w_head.burstcount == 8'd0) ? 8'd1 : w_head.burstcount;

    // Engine: load a command from the queue, then issue one beat per cycle;
    // the next command is loaded on the last beat so bursts chain seamlessly.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_rd_rem_nxt   = r_rd_rem;
        w_pop          = 1'b0;
        w_issue        = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_rd_ptr_nxt   = w_head_ptr;
                    w_rd_rem_nxt   = w_head_len;
                    w_rd_state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                w_issue      = 1'b1;
                w_rd_ptr_nxt = r_rd_ptr + C_IDX_ONE;
                w_rd_rem_nxt = r_rd_rem - 8'd1;
                if (r_rd_rem == 8'd1) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_rd_ptr_nxt = w_head_ptr;
                        w_rd_rem_nxt = w_head_len;
                    end else begin
                        w_rd_state_nxt = RD_IDLE;
                    end
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= RD_IDLE;
            r_rd_ptr   <= '0;
            r_rd_rem   <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_rd_rem   <= w_rd_rem_nxt;
        end
    end

    // Latency pipeline: stage 0 captures the RAM word at issue, the valid bit
    // and data then travel together to the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) r_dat[i] <= '0;
        end else begin
            r_vld[0] <= w_issue;
            if (w_issue) r_dat[0] <= r_mem[r_rd_ptr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Debug counters and outputs
    // ------------------------------------------------------------------
    // Wrapping beat counters for returned reads and accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_beats <= '0;
            r_wr_beats <= '0;
        end else begin
            if (avs_readdatavalid) r_rd_beats <= r_rd_beats + 16'd1;
            if (w_wr_acc)          r_wr_beats <= r_wr_beats + 16'd1;
        end
    end

    assign avs_readdata      = r_dat[RD_LATENCY-1];
    assign avs_readdatavalid = r_vld[RD_LATENCY-1];
    assign avs_waitrequest   = w_waitrequest;
    assign dbg_rd_beats      = r_rd_beats;
    assign dbg_wr_beats      = r_wr_beats;
    assign dbg_outstanding   = 4'(w_fifo_count) + ((r_rd_state == RD_ISSUE) ? 4'd1 : 4'd0);

    // Address bits outside the RAM index are ignored by design.
    assign w_unused_bits = ^{avs_address, w_head.index};

endmodule
`default_nettype wire

// File: tb/tb_ddr3_avmm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_avmm_responder
// Brief    : Self-checking bench: directed scenarios plus a randomized phase,
//            checked against a word-array memory model and an in-order queue
//            of expected read beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_avmm_responder;

    localparam int ADDR_W     = 12;
    localparam int RD_LATENCY = 4;
    localparam int CMD_DEPTH  = 4;
    localparam int STALL_EN   = 0;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int LIMIT      = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [28:0] avs_address;
    logic [7:0]  avs_burstcount;
    logic        avs_read;
    logic        avs_write;
    logic [63:0] avs_writedata;
    logic [7:0]  avs_byteenable;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;
    logic [15:0] dbg_rd_beats;
    logic [15:0] dbg_wr_beats;
    logic [3:0]  dbg_outstanding;

    ddr3_avmm_responder #(
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (RD_LATENCY),
        .CMD_DEPTH  (CMD_DEPTH),
        .STALL_EN   (STALL_EN)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .avs_address       (avs_address),
        .avs_burstcount    (avs_burstcount),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .dbg_rd_beats      (dbg_rd_beats),
        .dbg_wr_beats      (dbg_wr_beats),
        .dbg_outstanding   (dbg_outstanding)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_rd_beats = 0;
    int          m_wr_beats = 0;
    int          peak = 0;
    logic [63:0] m_mem [DEPTH];
    logic [63:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [28:0] mkaddr(input int idx);
        logic [31:0] r;
        logic [28:0] a;
        r = $urandom;
        a = r[28:0];
        a[ADDR_W+2:3] = idx[ADDR_W-1:0];
        return a;
    endfunction

    // Every returned beat must be expected, and match the oldest expectation.
    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("rd_data", avs_readdata, exp_q.pop_front());
            m_rd_beats++;
        end
        if (int'(dbg_outstanding) > peak) peak = int'(dbg_outstanding);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic write_burst(input int idx, input int n, input logic [63:0] d0,
                               input bit rnd, input logic [7:0] be, input bit with_read,
                               output int waits);
        logic [63:0] d;
        int w;
        waits = 0;
        for (int k = 0; k < n; k++) begin
            d = rnd ? {$urandom, $urandom} : d0 + 64'(k);
            avs_write      = 1'b1;
            avs_read       = with_read;
            avs_address    = (k == 0) ? mkaddr(idx) : mkaddr(int'($urandom));
            avs_burstcount = 8'(n);
            avs_writedata  = d;
            avs_byteenable = be;
            w = 0;
            @(negedge clk);
            while (avs_waitrequest === 1'b1 && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
            chk("wr_accept_timeout", 64'(w < LIMIT), 64'd1);
            for (int b = 0; b < 8; b++)
                if (be[b]) m_mem[(idx + k) % DEPTH][8*b +: 8] = d[8*b +: 8];
            m_wr_beats++;
            waits += w;
            @(posedge clk);
            #1;
        end
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    task automatic read_cmd(input int idx, input int n, output int waits);
        int w;
        int beats;
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        avs_address    = mkaddr(idx);
        avs_burstcount = 8'(n);
        w = 0;
        @(negedge clk);
        while (avs_waitrequest === 1'b1 && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk("rd_accept_timeout", 64'(w < LIMIT), 64'd1);
        beats = (n == 0) ? 1 : n;
        for (int k = 0; k < beats; k++) exp_q.push_back(m_mem[(idx + k) % DEPTH]);
        waits = w;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        cycles(2);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_dbg_rd_beats"}, 64'(dbg_rd_beats), 64'(m_rd_beats[15:0]));
        chk({tag, "_dbg_wr_beats"}, 64'(dbg_wr_beats), 64'(m_wr_beats[15:0]));
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (avs_readdatavalid !== 1'b1 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(k < LIMIT), 64'd1);
    endtask

    initial begin
        int w;
        int k;
        int idx;
        int win;
        logic [63:0] nd;

        rst_n          = 1'b0;
        avs_address    = '0;
        avs_burstcount = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_waitrequest", 64'(avs_waitrequest), 64'd1);
        chk("rst_readdatavalid", 64'(avs_readdatavalid), 64'd0);
        chk("rst_readdata", avs_readdata, 64'd0);
        chk("rst_dbg_rd", 64'(dbg_rd_beats), 64'd0);
        chk("rst_dbg_wr", 64'(dbg_wr_beats), 64'd0);
        chk("rst_dbg_out", 64'(dbg_outstanding), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_wait_edge1", 64'(avs_waitrequest), 64'd1);
        @(negedge clk);
        chk("release_wait_edge2", 64'(avs_waitrequest), 64'd0);
        @(posedge clk);
        #1;

        // Single write then read, with first-beat latency.
        write_burst('h0C8, 1, 64'h0123_4567_89AB_CDEF, 1'b0, 8'hFF, 1'b0, w);
        read_cmd('h0C8, 1, w);
        k = 0;
        @(negedge clk);
        while (avs_readdatavalid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rd_latency", 64'(k), 64'(1 + RD_LATENCY));
        @(posedge clk);
        #1;
        drain();
        check_counters("single");

        // Byte enables.
        write_burst('h123, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'hFF, 1'b0, w);
        write_burst('h123, 1, 64'h0, 1'b0, 8'h0F, 1'b0, w);
        read_cmd('h123, 1, w);
        drain();

        // Wrapping 4-beat burst write and read; beats must be back-to-back.
        write_burst('hFFE, 4, 64'd1, 1'b0, 8'hFF, 1'b0, w);
        read_cmd('hFFE, 4, w);
        wait_valid("burst_first_timeout");
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            chk("burst_consecutive", 64'(avs_readdatavalid), 64'd1);
        end
        @(posedge clk);
        #1;
        drain();
        check_counters("burst");

        // Fill the whole RAM with random data so any index can be read.
        for (int b = 0; b < DEPTH; b += 128) write_burst(b, 128, 64'd0, 1'b1, 8'hFF, 1'b0, w);
        cycles(2);
        check_counters("prefill");

        // Read and write together: write wins, no read beat appears.
        idx = int'($urandom_range(0, DEPTH - 1));
        write_burst(idx, 1, 64'd0, 1'b1, 8'hFF, 1'b1, w);
        cycles(20);
        read_cmd(idx, 0, w);
        drain();
        check_counters("rw_collide");

        // Queue full: one long burst keeps the engine busy while singles queue.
        peak = 0;
        idx = int'($urandom_range(0, DEPTH - 1));
        read_cmd(idx, 32, w);
        for (int j = 0; j < 4; j++) read_cmd(int'($urandom_range(0, DEPTH - 1)), 1, w);
        read_cmd(int'($urandom_range(0, DEPTH - 1)), 1, w);
        chk("fifo_full_held", 64'(w > 0), 64'd1);
        chk("outstanding_peak", 64'(peak), 64'd5);
        drain();

        // Read-after-write ordering: the write waits, earlier reads see old data.
        idx = int'($urandom_range(0, DEPTH - 1));
        read_cmd(idx, 8, w);
        nd = {$urandom, $urandom};
        write_burst(idx, 1, nd, 1'b0, 8'hFF, 1'b0, w);
        chk("raw_write_held", 64'(w > 0), 64'd1);
        read_cmd(idx, 1, w);
        drain();
        check_counters("raw");

        // Randomized mix of bursts in a small window to force overlaps.
        win = int'($urandom_range(0, DEPTH - 1));
        for (int op = 0; op < 60; op++) begin
            idx = (win + int'($urandom_range(0, 15))) % DEPTH;
            if ($urandom_range(0, 1) == 1)
                write_burst(idx, int'($urandom_range(1, 8)), 64'd0, 1'b1, 8'($urandom), 1'b0, w);
            else
                read_cmd(idx, int'($urandom_range(0, 8)), w);
        end
        drain();
        check_counters("random");

        // Reset in the middle of a read burst.
        read_cmd(int'($urandom_range(0, DEPTH - 1)), 16, w);
        wait_valid("midrst_first_timeout");
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_rd_beats = 0;
        m_wr_beats = 0;
        @(negedge clk);
        chk("midrst_valid", 64'(avs_readdatavalid), 64'd0);
        chk("midrst_readdata", avs_readdata, 64'd0);
        chk("midrst_outstanding", 64'(dbg_outstanding), 64'd0);
        check_counters("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_wait_edge1", 64'(avs_waitrequest), 64'd1);
        @(negedge clk);
        chk("midrst_wait_edge2", 64'(avs_waitrequest), 64'd0);
        @(posedge clk);
        #1;
        cycles(30);
        read_cmd(int'($urandom_range(0, DEPTH - 1)), 2, w);
        drain();
        check_counters("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
